next_button_conditioner: RTL and testbench
==========================================

Name: next_button_conditioner

Overview:
- Input-conditioning stage directly upstream of the calculator top level.
- Takes the raw mechanical "next" push-button plus the raw Din and MS switch buses. Synchronises and debounces the button.
- Emits exactly one single-cycle next_pulse per clean press, together with a Din/MS snapshot captured in that same cycle.
- The calculator FSM consumes next_pulse, din_q and ms_q instead of raw pins, so bounce can no longer advance it through several states.

Parameters:
- DATA_W, 16, width of the Din operand bus.
- MS_W, 3, width of the MS mode-select bus.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to accept a press or a release. Legal range 2 to 2^CNT_W-1. Board builds override it, e.g. 1000000.
- CNT_W, 20, width of the debounce counter.

Ports:
- clk  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-low reset.
- next_raw  in  1  raw push-button level, asynchronous to clk, may bounce.
- din_raw  in  DATA_W  raw operand switches.
- ms_raw  in  MS_W  raw mode-select switches.
- enable  in  1  pulse generation enable; when 0, presses are tracked but produce no pulse or capture.
- next_pulse  out  1  one-cycle strobe per accepted press.
- din_q  out  DATA_W  Din snapshot taken with the last pulse.
- ms_q  out  MS_W  MS snapshot taken with the last pulse.
- btn_level  out  1  debounced button level.
- data_valid  out  1  high once at least one snapshot has been taken since reset.

Behaviour:
- Reset (clear=0, asynchronous):
  - state=IDLE, count=0, both sync flops=0.
  - next_pulse=0, din_q=0, ms_q=0, btn_level=0, data_valid=0.
  - Release of reset is synchronous to clk.
  - Reset mid-debounce discards the partial count; no pulse is produced.
- Synchroniser:
  - next_raw passes through 2 flops, giving next_s.
  - All FSM decisions use next_s only.
  - din_raw and ms_raw are not synchronised; they are sampled only on the capture cycle and are assumed static while the button is held.
- FSM, all outputs registered:
  - IDLE: if next_s=1, go to PRESS_WAIT with count=1. Otherwise stay.
  - PRESS_WAIT:
    - next_s=0: go to IDLE, count=0 (bounce rejected).
    - next_s=1 and count<DEBOUNCE_CYCLES-1: count+1.
    - next_s=1 and count=DEBOUNCE_CYCLES-1: go to PRESSED, count=0. If enable=1, also next_pulse=1, din_q<=din_raw, ms_q<=ms_raw, data_valid<=1.
  - PRESSED: if next_s=0, go to RELEASE_WAIT with count=1. Otherwise stay; no further pulses however long the button is held.
  - RELEASE_WAIT:
    - next_s=1: go back to PRESSED, count=0.
    - next_s=0 and count<DEBOUNCE_CYCLES-1: count+1.
    - next_s=0 and count=DEBOUNCE_CYCLES-1: go to IDLE, count=0.
    - A release never pulses.
- next_pulse is high for exactly one cycle and 0 in all other cycles.
- Latency: with next_raw first sampled high at edge k and held clean, next_pulse is high in the cycle following edge k+DEBOUNCE_CYCLES+1.
- btn_level = 1 in PRESSED and RELEASE_WAIT, 0 otherwise.
- din_q, ms_q and data_valid hold their values until the next capture or reset.
- enable is sampled only on the acceptance edge. If enable=0 then, the FSM still enters PRESSED and the press is consumed: no pulse is produced, even if enable rises while the button is held.
- The counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.

Test Plan:
- Reset: clear=0 with next_raw=1, din_raw=16'h1234 -> all outputs 0; no pulse for 20 cycles while held. After clear=1 with next_raw still held high -> exactly one pulse, at the edge-k+5 latency with DEBOUNCE_CYCLES=4.
- Clean press: DEBOUNCE_CYCLES=4, din_raw=16'h0001, ms_raw=3'b001, next_raw high for 20 cycles from edge k -> next_pulse high only after edge k+5, din_q=16'h0001, ms_q=3'b001, data_valid=1. btn_level=1 until 5 cycles after release.
- Bounce rejection: next_raw toggles 1,0,1,1,0,1 per cycle, then held high -> no pulse during the bounce; exactly one pulse 4 stable samples after next_s settles high.
- Long hold and release bounce: press held 100 cycles, release with 3 bounces -> exactly one pulse in total. A second clean press with din_raw=16'h0003 -> second pulse, din_q=16'h0003.
- Enable gating: enable=0 at acceptance, din_raw=16'hFFFF -> no pulse, din_q unchanged, btn_level=1. Raising enable mid-hold -> still no pulse. Next press with enable=1 -> pulse.
- Reset mid-operation: clear=0 while in PRESS_WAIT (count=2) -> immediately state=IDLE and outputs zero. Button released during reset -> no pulse after reset release.

Source files
------------

// File: rtl/next_button_conditioner.sv
// next_button_conditioner: synchronises and debounces the raw "next" push-button
// and emits one single-cycle next_pulse per clean press. The Din and MS switch
// buses are snapshotted in the same cycle as the pulse.
module next_button_conditioner #(
    parameter int unsigned DATA_W          = 16,
    parameter int unsigned MS_W            = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 20
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              next_raw,
    input  logic [DATA_W-1:0] din_raw,
    input  logic [MS_W-1:0]   ms_raw,
    input  logic              enable,
    output logic              next_pulse,
    output logic [DATA_W-1:0] din_q,
    output logic [MS_W-1:0]   ms_q,
    output logic              btn_level,
    output logic              data_valid
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic              sync1_q, sync2_q;
    logic              next_s;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pulse_q, pulse_d;
    logic [DATA_W-1:0] din_d;
    logic [MS_W-1:0]   ms_d;
    logic              level_q, level_d;
    logic              valid_q, valid_d;

    assign next_s     = sync2_q;
    assign next_pulse = pulse_q;
    assign btn_level  = level_q;
    assign data_valid = valid_q;

    // Two-flop synchroniser for the asynchronous button level.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= next_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce FSM next-state, counter and registered-output logic.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pulse_d = 1'b0;
        din_d   = din_q;
        ms_d    = ms_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (next_s) begin
                    state_d = PRESS_WAIT;
                    count_d = CNT_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (!next_s) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (count_q != CNT_LAST) begin
                    count_d = count_q + CNT_W'(1);
                end else begin
                    // Acceptance edge: enable is only looked at here, so a press
                    // accepted while disabled is consumed without a pulse.
                    state_d = PRESSED;
                    count_d = '0;
                    if (enable) begin
                        pulse_d = 1'b1;
                        din_d   = din_raw;
                        ms_d    = ms_raw;
                        valid_d = 1'b1;
                    end
                end
            end
            PRESSED: begin
                if (!next_s) begin
                    state_d = RELEASE_WAIT;
                    count_d = CNT_W'(1);
                end
            end
            RELEASE_WAIT: begin
                if (next_s) begin
                    state_d = PRESSED;
                    count_d = '0;
                end else if (count_q != CNT_LAST) begin
                    count_d = count_q + CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    count_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    // FSM state, counter and registered outputs.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            count_q <= '0;
            pulse_q <= 1'b0;
            din_q   <= '0;
            ms_q    <= '0;
            level_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pulse_q <= pulse_d;
            din_q   <= din_d;
            ms_q    <= ms_d;
            level_q <= level_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_next_button_conditioner.sv
// Bench for next_button_conditioner: directed scenarios plus randomized button
// activity, checked every cycle against a run-length model of the debouncer.
module tb_next_button_conditioner;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic        next_raw = 1'b0;
    logic [15:0] din_raw = '0;
    logic [2:0]  ms_raw = '0;
    logic        enable = 1'b1;
    logic        next_pulse;
    logic [15:0] din_q;
    logic [2:0]  ms_q;
    logic        btn_level;
    logic        data_valid;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int last_pulse_cyc = -1;

    next_button_conditioner #(
        .DATA_W(16),
        .MS_W(3),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(20)
    ) dut (
        .clk(clk),
        .clear(clear),
        .next_raw(next_raw),
        .din_raw(din_raw),
        .ms_raw(ms_raw),
        .enable(enable),
        .next_pulse(next_pulse),
        .din_q(din_q),
        .ms_q(ms_q),
        .btn_level(btn_level),
        .data_valid(data_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: the debounced level flips once the synchronised button
    // (raw level two edges late) has shown DB consecutive samples at the new value.
    logic [1:0]  m_dly;
    int          m_ones, m_zeros;
    logic        m_level, m_pulse, m_valid;
    logic [15:0] m_din;
    logic [2:0]  m_ms;
    logic        m_ns, m_press, m_rel;
    int          m_o_nxt, m_z_nxt;

    always_comb begin
        m_ns    = m_dly[1];
        m_o_nxt = m_ns ? ((m_ones < 1000) ? m_ones + 1 : m_ones) : 0;
        m_z_nxt = !m_ns ? ((m_zeros < 1000) ? m_zeros + 1 : m_zeros) : 0;
        m_press = !m_level && (m_o_nxt >= DB);
        m_rel   = m_level && (m_z_nxt >= DB);
    end

    always @(posedge clk or negedge clear) begin
        if (!clear) begin
            m_dly   <= '0;
            m_ones  <= 0;
            m_zeros <= 0;
            m_level <= 1'b0;
            m_pulse <= 1'b0;
            m_valid <= 1'b0;
            m_din   <= '0;
            m_ms    <= '0;
        end else begin
            m_dly   <= {m_dly[0], next_raw};
            m_ones  <= m_o_nxt;
            m_zeros <= m_z_nxt;
            m_pulse <= m_press && enable;
            if (m_press && enable) begin
                m_din   <= din_raw;
                m_ms    <= ms_raw;
                m_valid <= 1'b1;
            end
            if (m_press) m_level <= 1'b1;
            else if (m_rel) m_level <= 1'b0;
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (next_pulse === 1'b1) begin
            pulse_cnt++;
            last_pulse_cyc = cyc;
        end
        check("next_pulse", 32'(next_pulse), 32'(m_pulse));
        check("din_q", 32'(din_q), 32'(m_din));
        check("ms_q", 32'(ms_q), 32'(m_ms));
        check("btn_level", 32'(btn_level), 32'(m_level));
        check("data_valid", 32'(data_valid), 32'(m_valid));
    end

    task automatic drive(input logic raw);
        @(posedge clk);
        #2;
        next_raw = raw;
    endtask

    task automatic hold(input logic raw, input int n);
        for (int i = 0; i < n; i++) drive(raw);
    endtask

    initial begin
        int e;
        int p0;
        logic [7:0] bseq;

        // Reset held with the button pressed: nothing may come out.
        clear = 1'b0;
        next_raw = 1'b1;
        din_raw = 16'h1234;
        ms_raw = 3'b101;
        hold(1'b1, 20);
        check("rst_pulses", 32'(pulse_cnt), 32'd0);
        check("rst_din", 32'(din_q), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_level", 32'(btn_level), 32'd0);

        // Release reset with the button still held: one pulse at k+5.
        @(posedge clk);
        #2;
        clear = 1'b1;
        e = cyc;
        hold(1'b1, 20);
        check("rst_rel_pulses", 32'(pulse_cnt), 32'd1);
        check("rst_rel_latency", 32'(last_pulse_cyc), 32'(e + 6));
        check("rst_rel_din", 32'(din_q), 32'h1234);
        hold(1'b0, 10);
        check("rel_level", 32'(btn_level), 32'd0);

        // Clean press.
        din_raw = 16'h0001;
        ms_raw = 3'b001;
        p0 = pulse_cnt;
        hold(1'b1, 20);
        check("clean_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("clean_din", 32'(din_q), 32'h0001);
        check("clean_ms", 32'(ms_q), 32'd1);
        check("clean_valid", 32'(data_valid), 32'd1);
        check("clean_level", 32'(btn_level), 32'd1);
        hold(1'b0, 10);

        // Press bounce 1,0,1,1,0,1 then held high.
        p0 = pulse_cnt;
        bseq = 8'b0010_1101;
        for (int i = 0; i < 6; i++) drive(bseq[i]);
        check("bounce_nopulse", 32'(pulse_cnt - p0), 32'd0);
        hold(1'b1, 15);
        check("bounce_pulses", 32'(pulse_cnt - p0), 32'd1);
        hold(1'b0, 10);

        // Long hold, bouncy release, then a second clean press.
        p0 = pulse_cnt;
        din_raw = 16'h0002;
        hold(1'b1, 100);
        for (int i = 0; i < 7; i++) drive(1'(i % 2));
        hold(1'b0, 15);
        check("long_pulses", 32'(pulse_cnt - p0), 32'd1);
        din_raw = 16'h0003;
        hold(1'b1, 15);
        check("second_pulses", 32'(pulse_cnt - p0), 32'd2);
        check("second_din", 32'(din_q), 32'h0003);
        hold(1'b0, 10);

        // Enable gating.
        p0 = pulse_cnt;
        enable = 1'b0;
        din_raw = 16'hFFFF;
        hold(1'b1, 10);
        enable = 1'b1;
        hold(1'b1, 10);
        check("gate_pulses", 32'(pulse_cnt - p0), 32'd0);
        check("gate_din", 32'(din_q), 32'h0003);
        check("gate_level", 32'(btn_level), 32'd1);
        hold(1'b0, 10);
        hold(1'b1, 15);
        check("gate_next_pulse", 32'(pulse_cnt - p0), 32'd1);
        check("gate_next_din", 32'(din_q), 32'hFFFF);
        hold(1'b0, 10);

        // Reset during PRESS_WAIT with count at 2.
        p0 = pulse_cnt;
        drive(1'b1);
        hold(1'b1, 4);
        clear = 1'b0;
        #1;
        check("midrst_level", 32'(btn_level), 32'd0);
        check("midrst_din", 32'(din_q), 32'd0);
        check("midrst_valid", 32'(data_valid), 32'd0);
        check("midrst_pulse", 32'(next_pulse), 32'd0);
        next_raw = 1'b0;
        hold(1'b0, 5);
        clear = 1'b1;
        hold(1'b0, 20);
        check("midrst_pulses", 32'(pulse_cnt - p0), 32'd0);

        // Randomized activity: bursts of bounce followed by stable stretches.
        for (int it = 0; it < 300; it++) begin
            int blen;
            int slen;
            logic lvl;
            enable = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 2) == 0) begin
                din_raw = 16'($urandom);
                ms_raw = 3'($urandom);
            end
            blen = $urandom_range(0, 6);
            for (int j = 0; j < blen; j++) drive(1'($urandom));
            lvl = 1'($urandom);
            slen = $urandom_range(1, 12);
            hold(lvl, slen);
            if ($urandom_range(0, 39) == 0) begin
                clear = 1'b0;
                hold(1'($urandom), 2);
                clear = 1'b1;
            end
        end
        hold(1'b0, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
